// File: rtl/seq_timing_ctrl_team1.sv
// seq_timing_ctrl_team1
// Timing and interrupt control stage ahead of the PC control logic.
// It owns the sequence counter SC and decodes it into the one-hot timing bus T.
// It owns the interrupt-cycle flop R, the interrupt enable IEN and the run flop S.
// It also produces the register-reference strobe r and the I/O strobe p.
//
// Optional build macro: SC_OVF_TRAP_EN. When it is defined, an SC overflow
// halts the stage and sets the sticky ILLEGAL flag. When it is undefined, SC
// wraps silently and ILLEGAL is tied low.
//
// Ports:
//   clk         system clock, all state updates on posedge
//   CLR_GLOBAL  synchronous active-high reset
//   START       single-cycle pulse, sets S
//   D[7:0]      one-hot decoded opcode
//   I           IR[15] indirect/type bit
//   B[11:0]     IR[11:0] microop bits
//   FGI, FGO    input/output flags
//   T           one-hot timing signals, all zero while halted
//   SC          current sequence count
//   R, IEN, S   interrupt-cycle, interrupt-enable and run flops
//   r, p        register-reference and I/O strobes
//   ILLEGAL     sticky SC overflow flag (SC_OVF_TRAP_EN builds only)
module seq_timing_ctrl_team1 #(
   parameter int unsigned SC_WIDTH     = 4,
   parameter bit          RUN_AT_RESET = 1'b1
) (
   input  logic                     clk,
   input  logic                     CLR_GLOBAL,
   input  logic                     START,
   input  logic [7:0]               D,
   input  logic                     I,
   input  logic [11:0]              B,
   input  logic                     FGI,
   input  logic                     FGO,
   output logic [(2**SC_WIDTH)-1:0] T,
   output logic [SC_WIDTH-1:0]      SC,
   output logic                     R,
   output logic                     IEN,
   output logic                     S,
   output logic                     r,
   output logic                     p,
   output logic                     ILLEGAL
);

   logic sc_clr;
   logic hlt;
   logic r_set;
   logic r_clr;
   logic ien_set;
   logic ien_clr;

   // Only ION (B[7]), IOF (B[6]) and HLT (B[0]) are decoded here.
   logic unused_b;
   assign unused_b = ^{B[11:8], B[5:1]};

   always_comb begin
      T = '0;
      if (S) T[SC] = 1'b1;
   end

   assign r = D[7] & ~I & T[3];
   assign p = D[7] &  I & T[3];

   // End of instruction: the interrupt cycle, or the last T step of each opcode.
   assign sc_clr = (R & T[2])
                 | ((D[0] | D[1] | D[2] | D[5]) & T[5])
                 | ((D[3] | D[4]) & T[4])
                 | (D[6] & T[6])
                 | r | p;

   assign hlt     = r & B[0];
   // T is all zero while S=0, so R can neither set nor clear while halted.
   assign r_set   = S & ~T[0] & ~T[1] & ~T[2] & IEN & (FGI | FGO);
   assign r_clr   = R & T[2];
   assign ien_set = p & B[7];
   assign ien_clr = (p & B[6]) | r_clr;

`ifdef SC_OVF_TRAP_EN
   logic ovf;
   assign ovf = S & ~sc_clr & (SC == '1);
`endif

   always_ff @(posedge clk) begin
      if (CLR_GLOBAL) begin
         SC  <= '0;
         R   <= 1'b0;
         IEN <= 1'b0;
         S   <= RUN_AT_RESET;
      end else begin
         if (S) begin
            if (sc_clr) SC <= '0;
            else        SC <= SC + SC_WIDTH'(1);
         end

         if (r_clr)      R <= 1'b0;
         else if (r_set) R <= 1'b1;

         if (ien_clr)      IEN <= 1'b0;
         else if (ien_set) IEN <= 1'b1;

         if (hlt)        S <= 1'b0;
         else if (START) S <= 1'b1;
`ifdef SC_OVF_TRAP_EN
         // On overflow, SC+1 already wraps to 0, so only S needs overriding.
         if (ovf) S <= 1'b0;
`endif
      end
   end

`ifdef SC_OVF_TRAP_EN
   always_ff @(posedge clk) begin
      if (CLR_GLOBAL) ILLEGAL <= 1'b0;
      else if (ovf)   ILLEGAL <= 1'b1;
   end
`else
   assign ILLEGAL = 1'b0;
`endif

endmodule

// File: tb/tb_seq_timing_ctrl_team1.sv
// tb_seq_timing_ctrl_team1
// Scoreboard bench for seq_timing_ctrl_team1 at its default parameters.
// Each test task queues per-cycle stimulus together with the expected
// {T, SC, R, IEN, S, ILLEGAL, r, p} for that cycle, then drains the queue.
module tb_seq_timing_ctrl_team1;

   logic        clk = 1'b0;
   logic        CLR_GLOBAL, START, I, FGI, FGO;
   logic [7:0]  D;
   logic [11:0] B;
   logic [15:0] T;
   logic [3:0]  SC;
   logic        R, IEN, S, r, p, ILLEGAL;

   typedef struct packed {
      logic        clr;
      logic        start;
      logic [7:0]  d;
      logic        i;
      logic [11:0] b;
      logic        fgi;
      logic        fgo;
   } stim_t;

   typedef struct {
      string       name;
      logic [25:0] v;
   } exp_t;

   stim_t stim_q[$];
   exp_t  exp_q[$];
   stim_t cur;
   int    n_total = 0;
   int    n_pass  = 0;

   always #5 clk = ~clk;

   seq_timing_ctrl_team1 #(.SC_WIDTH(4), .RUN_AT_RESET(1'b1)) dut (
      .clk(clk), .CLR_GLOBAL(CLR_GLOBAL), .START(START), .D(D), .I(I), .B(B),
      .FGI(FGI), .FGO(FGO), .T(T), .SC(SC), .R(R), .IEN(IEN), .S(S),
      .r(r), .p(p), .ILLEGAL(ILLEGAL)
   );

   function automatic logic [25:0] observed();
      return {T, SC, R, IEN, S, ILLEGAL, r, p};
   endfunction

   // Queue the current stimulus and the state expected during that cycle.
   function automatic void add(input string name, input logic [3:0] sc,
                               input logic rr, ien, s, rs, ps,
                               input logic ill = 1'b0);
      exp_t        e;
      logic [15:0] t;
      t      = s ? (16'h0001 << sc) : 16'h0000;
      e.name = name;
      e.v    = {t, sc, rr, ien, s, ill, rs, ps};
      stim_q.push_back(cur);
      exp_q.push_back(e);
   endfunction

   task automatic apply(input stim_t st);
      CLR_GLOBAL = st.clr;
      START      = st.start;
      D          = st.d;
      I          = st.i;
      B          = st.b;
      FGI        = st.fgi;
      FGO        = st.fgo;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      cur = '0;
      cur.clr = 1'b1;
      apply(cur);
      tick();
      cur = '0;
   endtask

   task automatic test_reset();
      exp_t e;
      do_reset();
      cur.d = 8'h10;
      for (int k = 0; k < 5; k++) add($sformatf("run_T%0d", k), 4'(k), 0, 0, 1, 0, 0);
      add("run_D4_end", 0, 0, 0, 1, 0, 0);
      add("run_next_T1", 1, 0, 0, 1, 0, 0);
      cur.clr = 1'b1;
      add("rst_mid_T2", 2, 0, 0, 1, 0, 0);
      cur.clr = 1'b0;
      add("rst_mid_after", 0, 0, 0, 1, 0, 0);
      while (exp_q.size() != 0) begin
         apply(stim_q.pop_front());
         #2;
         e = exp_q.pop_front();
         n_total++;
         if (observed() !== e.v)
            $display("FAIL %s: got {T,SC,R,IEN,S,ILL,r,p}=%h want %h", e.name, observed(), e.v);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_ion_interrupt();
      exp_t e;
      do_reset();
      cur.d = 8'h80; cur.i = 1'b1; cur.b = 12'h080;
      for (int k = 0; k < 3; k++) add($sformatf("ion_T%0d", k), 4'(k), 0, 0, 1, 0, 0);
      add("ion_T3_p", 3, 0, 0, 1, 0, 1);
      cur.d = 8'h10; cur.i = 1'b0; cur.b = 12'h000;
      for (int k = 0; k < 3; k++) add($sformatf("irq_wait_T%0d", k), 4'(k), 0, 1, 1, 0, 0);
      cur.fgi = 1'b1;
      add("irq_fgi_T3", 3, 0, 1, 1, 0, 0);
      cur.fgi = 1'b0;
      add("irq_R_set_T4", 4, 1, 1, 1, 0, 0);
      cur.d = 8'h00;
      for (int k = 0; k < 3; k++) add($sformatf("icyc_T%0d", k), 4'(k), 1, 1, 1, 0, 0);
      add("icyc_done", 0, 0, 0, 1, 0, 0);
      while (exp_q.size() != 0) begin
         apply(stim_q.pop_front());
         #2;
         e = exp_q.pop_front();
         n_total++;
         if (observed() !== e.v)
            $display("FAIL %s: got {T,SC,R,IEN,S,ILL,r,p}=%h want %h", e.name, observed(), e.v);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_r_window();
      exp_t e;
      do_reset();
      cur.d = 8'h80; cur.i = 1'b1; cur.b = 12'h080;
      for (int k = 0; k < 3; k++) add($sformatf("win_ion_T%0d", k), 4'(k), 0, 0, 1, 0, 0);
      add("win_ion_T3", 3, 0, 0, 1, 0, 1);
      cur.d = 8'h10; cur.i = 1'b0; cur.b = 12'h000;
      add("win_T0", 0, 0, 1, 1, 0, 0);
      cur.fgo = 1'b1;
      add("win_T1_fgo", 1, 0, 1, 1, 0, 0);
      add("win_T2", 2, 0, 1, 1, 0, 0);
      add("win_T3", 3, 0, 1, 1, 0, 0);
      add("win_R_T4", 4, 1, 1, 1, 0, 0);
      while (exp_q.size() != 0) begin
         apply(stim_q.pop_front());
         #2;
         e = exp_q.pop_front();
         n_total++;
         if (observed() !== e.v)
            $display("FAIL %s: got {T,SC,R,IEN,S,ILL,r,p}=%h want %h", e.name, observed(), e.v);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_hlt();
      exp_t e;
      do_reset();
      cur.d = 8'h80; cur.i = 1'b0; cur.b = 12'h001;
      for (int k = 0; k < 3; k++) add($sformatf("hlt_T%0d", k), 4'(k), 0, 0, 1, 0, 0);
      add("hlt_T3_r", 3, 0, 0, 1, 1, 0);
      for (int k = 0; k < 10; k++) add($sformatf("halt_hold%0d", k), 0, 0, 0, 0, 0, 0);
      cur.d = 8'h00; cur.b = 12'h000; cur.start = 1'b1;
      add("start_pulse", 0, 0, 0, 0, 0, 0);
      cur.start = 1'b0;
      add("restart_T0", 0, 0, 0, 1, 0, 0);
      add("restart_T1", 1, 0, 0, 1, 0, 0);
      while (exp_q.size() != 0) begin
         apply(stim_q.pop_front());
         #2;
         e = exp_q.pop_front();
         n_total++;
         if (observed() !== e.v)
            $display("FAIL %s: got {T,SC,R,IEN,S,ILL,r,p}=%h want %h", e.name, observed(), e.v);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_priority();
      exp_t e;
      do_reset();
      cur.d = 8'h80; cur.i = 1'b0; cur.b = 12'h001;
      for (int k = 0; k < 3; k++) add($sformatf("pri_T%0d", k), 4'(k), 0, 0, 1, 0, 0);
      cur.start = 1'b1;
      add("pri_start_hlt", 3, 0, 0, 1, 1, 0);
      cur.start = 1'b0;
      add("pri_halted", 0, 0, 0, 0, 0, 0);
      cur.d = 8'h00; cur.b = 12'h000; cur.clr = 1'b1;
      add("pri_clr_halted", 0, 0, 0, 0, 0, 0);
      cur.clr = 1'b0; cur.d = 8'h80; cur.i = 1'b1; cur.b = 12'h080;
      add("pri_clr_run", 0, 0, 0, 1, 0, 0);
      cur.start = 1'b1;
      add("pri_start_running", 1, 0, 0, 1, 0, 0);
      cur.start = 1'b0;
      add("pri_T2", 2, 0, 0, 1, 0, 0);
      cur.clr = 1'b1;
      add("pri_clr_ion", 3, 0, 0, 1, 0, 1);
      cur.clr = 1'b0; cur.d = 8'h00;
      add("pri_after_clr", 0, 0, 0, 1, 0, 0);
      while (exp_q.size() != 0) begin
         apply(stim_q.pop_front());
         #2;
         e = exp_q.pop_front();
         n_total++;
         if (observed() !== e.v)
            $display("FAIL %s: got {T,SC,R,IEN,S,ILL,r,p}=%h want %h", e.name, observed(), e.v);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_overflow();
      exp_t e;
      do_reset();
      for (int k = 0; k < 16; k++) add($sformatf("ovf_T%0d", k), 4'(k), 0, 0, 1, 0, 0, 0);
`ifdef SC_OVF_TRAP_EN
      add("ovf_trap", 0, 0, 0, 0, 0, 0, 1);
      cur.clr = 1'b1;
      add("ovf_sticky", 0, 0, 0, 0, 0, 0, 1);
`else
      add("ovf_wrap", 0, 0, 0, 1, 0, 0, 0);
      cur.clr = 1'b1;
      add("ovf_wrap_T1", 1, 0, 0, 1, 0, 0, 0);
`endif
      cur.clr = 1'b0;
      add("ovf_after_clr", 0, 0, 0, 1, 0, 0, 0);
      while (exp_q.size() != 0) begin
         apply(stim_q.pop_front());
         #2;
         e = exp_q.pop_front();
         n_total++;
         if (observed() !== e.v)
            $display("FAIL %s: got {T,SC,R,IEN,S,ILL,r,p}=%h want %h", e.name, observed(), e.v);
         else n_pass++;
         tick();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
      $fatal(1, "time limit");
   end

   initial begin
      cur = '0;
      apply(cur);
      test_reset();
      test_ion_interrupt();
      test_r_window();
      test_hlt();
      test_priority();
      test_overflow();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/seq_timing_ctrl_team1.md
Name: seq_timing_ctrl_team1

Overview:
- Timing and interrupt control stage directly upstream of the PC control logic.
- Owns the sequence counter (SC) and decodes it into the one-hot timing bus T[15:0].
- Owns the interrupt-cycle flip-flop R, the interrupt enable IEN and the run flip-flop S.
- Also produces the register-reference strobe r and the I/O strobe p, which PCC, the PC register and the other datapath controls consume.

Parameters:
- SC_WIDTH, 4, sequence counter width; T width is 2**SC_WIDTH (16 at default).
- RUN_AT_RESET, 1, value loaded into S on reset (1 = free-running after reset).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- CLR_GLOBAL  input  1  synchronous, active-high reset.
- START  input  1  single-cycle pulse; sets S.
- D  input  8  decoded opcode D[7:0] from the instruction decoder; one-hot when valid.
- I  input  1  indirect/type bit from IR[15].
- B  input  12  IR[11:0] microop bits.
- FGI  input  1  input flag.
- FGO  input  1  output flag.
- T  output  16  one-hot timing signals; all zero while halted.
- SC  output  SC_WIDTH  current sequence count.
- R  output  1  interrupt-cycle flip-flop.
- IEN  output  1  interrupt enable flip-flop.
- S  output  1  run flip-flop.
- r  output  1  register-reference strobe = D[7] & ~I & T[3].
- p  output  1  I/O strobe = D[7] & I & T[3].
- ILLEGAL  output  1  sticky SC overflow flag; only present when SC_OVF_TRAP_EN is defined, otherwise tied 0.

Behaviour:
- Clock and reset: single clock clk. CLR_GLOBAL is synchronous and active-high and dominates every other event in the same cycle. Reset values: SC=0, R=0, IEN=0, S=RUN_AT_RESET, ILLEGAL=0.
- Timing decode: combinational from registered SC. T[k] = S & (SC==k), so T is one-hot when S=1 and all zero when S=0. r and p are combinational from D, I and T; zero latency.
- SC_CLR term (end of instruction), OR of: R&T[2], D[0]&T[5], D[1]&T[5], D[2]&T[5], D[3]&T[4], D[4]&T[4], D[5]&T[5], D[6]&T[6], r, p.
- SC update priority, highest first:
  - CLR_GLOBAL → SC=0.
  - S==0 → SC holds.
  - SC_CLR → SC=0.
  - Otherwise SC=SC+1, modulo 2**SC_WIDTH.
- R flip-flop:
  - Set when S & ~T[0] & ~T[1] & ~T[2] & IEN & (FGI|FGO).
  - Cleared when R&T[2].
  - Set and clear in the same cycle cannot occur, because set requires ~T[2].
  - R holds while S=0.
- IEN flip-flop:
  - Set by p&B[7] (ION).
  - Cleared by p&B[6] (IOF) or by R&T[2].
  - Clear wins if set and clear coincide.
- S flip-flop:
  - Set by START.
  - Cleared by r&B[0] (HLT).
  - If START and HLT coincide, HLT wins.
  - START while S=1 has no effect.
  - When S goes 0, the next cycle shows T=0 and SC frozen at its cleared value 0, because HLT also asserts SC_CLR via r.
- Interrupt cycle sequence: R=1 entering T0 → T0, T1, T2 → SC=0, R=0, IEN=0 at the clock edge ending T2.
- Reset mid-instruction: the next cycle shows SC=0, T[0]=1 (when RUN_AT_RESET=1), R=0, IEN=0.
- D not one-hot: no protection. The clear term ORs whatever is asserted.

Optional Feature:
- Macro: SC_OVF_TRAP_EN.
- Defined: when SC == 2**SC_WIDTH-1, S=1 and SC_CLR=0, the next edge forces SC=0, sets sticky ILLEGAL=1 and clears S. ILLEGAL is cleared only by CLR_GLOBAL.
- Undefined: SC wraps silently to 0 and ILLEGAL is constant 0.

Test Plan:
- Reset then run: assert CLR_GLOBAL 1 cycle, release → T sequence 0x0001, 0x0002, 0x0004, ...; with D=8'h10 (D4), T[4] active, then the next cycle SC=0, T=0x0001.
- ION then interrupt: D=8'h80, I=1, B=12'h080 at T3 → IEN=1, SC=0 next. Then FGI=1 during T3 of the next instruction → R=1 next cycle. Interrupt cycle T0..T2 runs, then R=0, IEN=0, SC=0.
- R set window: IEN=1, FGO=1 raised while SC=1 → R stays 0 until SC reaches 3, then R=1 one cycle later.
- HLT: D=8'h80, I=0, B=12'h001 at T3 → S=0, SC=0, T=16'h0000 held 10 cycles. START pulse → T=0x0001 next cycle.
- Priority: START and HLT in the same cycle → S=0. CLR_GLOBAL with ION strobe in the same cycle → IEN=0, SC=0.
- Overflow, D=0 with no clear term: run SC to 15. With SC_OVF_TRAP_EN defined → ILLEGAL=1, S=0, SC=0. Without → SC wraps to 0, T=0x0001, ILLEGAL=0.
